// File: rtl/video_pattern_gen.sv
// Frame-based RGB test-pattern source: ramp, colour bars, checkerboard, solid.
// Define VIDEO_PATGEN_SCROLL_EN to make ramp and checkerboard advance per frame.
module video_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int BPC        = 8,
   parameter int CHECK_LOG2 = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [1:0]         mode,
   input  logic [3*BPC-1:0]   solid_rgb,
   output logic [3*BPC-1:0]   pix_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic               pix_sof,
   output logic               pix_eol,
   output logic               pix_eof,
   output logic [15:0]        frame_cnt
);

   localparam int PW = 3 * BPC;
   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = (V_ACTIVE > 2) ? $clog2(V_ACTIVE) : 1;
   localparam int BW = H_ACTIVE / 8;
   localparam int SW = (BW > 1) ? $clog2(BW) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
   localparam logic [SW-1:0] S_LAST = SW'(BW - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t          r_state, w_state_nxt;
   logic [XW-1:0]   r_x, w_nx;
   logic [YW-1:0]   r_y, w_ny;
   logic [PW-1:0]   r_idx, w_nidx;
   logic [SW-1:0]   r_sub, w_nsub;
   logic [2:0]      r_bar, w_nbar;
   logic [1:0]      r_mode, w_nmode;
   logic [PW-1:0]   r_solid, w_nsolid;
   logic [15:0]     r_fc, w_nfc;
   logic [PW-1:0]   r_data, w_data;
   logic            r_valid, r_sof, r_eol, r_eof;
   logic            w_hs, w_start, w_adv, w_drop;
   logic [PW-1:0]   w_ramp, w_bar_rgb;
   logic [31:0]     w_cx, w_cy;
   logic            w_chk;

   assign w_hs = r_valid & pix_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_adv       = 1'b0;
      w_drop      = 1'b0;
      w_nfc       = r_fc;
      unique case (r_state)
         IDLE: begin
            if (enable) begin
               w_start     = 1'b1;
               w_state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (w_hs) begin
               if (r_eof) begin
                  w_nfc = r_fc + 16'd1;
                  if (enable) begin
                     w_start = 1'b1;
                  end else begin
                     w_drop      = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_adv = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Coordinates and bar sub-counter of the pixel to present next
   always_comb begin
      w_nx     = r_x;
      w_ny     = r_y;
      w_nidx   = r_idx;
      w_nsub   = r_sub;
      w_nbar   = r_bar;
      w_nmode  = r_mode;
      w_nsolid = r_solid;
      if (w_start) begin
         w_nx     = '0;
         w_ny     = '0;
         w_nidx   = '0;
         w_nsub   = '0;
         w_nbar   = '0;
         w_nmode  = mode;
         w_nsolid = solid_rgb;
      end else if (w_adv) begin
         w_nidx = r_idx + PW'(1);
         if (r_x == X_LAST) begin
            w_nx   = '0;
            w_ny   = r_y + YW'(1);
            w_nsub = '0;
            w_nbar = '0;
         end else begin
            w_nx = r_x + XW'(1);
            if (r_sub == S_LAST) begin
               w_nsub = '0;
               w_nbar = r_bar + 3'd1;
            end else begin
               w_nsub = r_sub + SW'(1);
            end
         end
      end
   end

   always_comb begin
`ifdef VIDEO_PATGEN_SCROLL_EN
      w_ramp = w_nidx + PW'(w_nfc);
      w_cx   = 32'(w_nx) + 32'(w_nfc[CHECK_LOG2+7:0]);
`else
      w_ramp = w_nidx;
      w_cx   = 32'(w_nx);
`endif
      w_cy  = 32'(w_ny);
      w_chk = |(((w_cx ^ w_cy) >> CHECK_LOG2) & 32'd1);
      // Bar order W,Y,C,G,M,R,B,K maps to R=~b[1], G=~b[2], B=~b[0]
      w_bar_rgb = {{BPC{~w_nbar[1]}}, {BPC{~w_nbar[2]}}, {BPC{~w_nbar[0]}}};
      w_data = '0;
      unique case (w_nmode)
         2'd0: w_data = w_ramp;
         2'd1: w_data = w_bar_rgb;
         2'd2: w_data = w_chk ? {PW{1'b1}} : '0;
         2'd3: w_data = w_nsolid;
         default: w_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_idx   <= '0;
         r_sub   <= '0;
         r_bar   <= '0;
         r_mode  <= '0;
         r_solid <= '0;
         r_fc    <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_eof   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_nx;
         r_y     <= w_ny;
         r_idx   <= w_nidx;
         r_sub   <= w_nsub;
         r_bar   <= w_nbar;
         r_mode  <= w_nmode;
         r_solid <= w_nsolid;
         r_fc    <= w_nfc;
         if (w_start || w_adv) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_sof   <= (w_nx == '0) && (w_ny == '0);
            r_eol   <= (w_nx == X_LAST);
            r_eof   <= (w_nx == X_LAST) && (w_ny == Y_LAST);
         end else if (w_drop) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
         end
      end
   end

   assign pix_data  = r_data;
   assign pix_valid = r_valid;
   assign pix_sof   = r_sof;
   assign pix_eol   = r_eol;
   assign pix_eof   = r_eof;
   assign frame_cnt = r_fc;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with a 16x4 frame.
// Checks ramp, bars, checkerboard with stalls, latching and reset.
module tb_video_pattern_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  mode;
   logic [23:0] solid_rgb;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sof;
   logic        pix_eol;
   logic        pix_eof;
   logic [15:0] frame_cnt;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic        g_apply = 1'b0;
   logic [1:0]  g_mode  = 2'd0;
   logic [23:0] g_solid = 24'd0;
   logic        g_en    = 1'b1;

   always #5 clk = ~clk;

   video_pattern_gen #(
      .H_ACTIVE   (16),
      .V_ACTIVE   (4),
      .BPC        (8),
      .CHECK_LOG2 (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .mode      (mode),
      .solid_rgb (solid_rgb),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_sof   (pix_sof),
      .pix_eol   (pix_eol),
      .pix_eof   (pix_eof),
      .frame_cnt (frame_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [23:0] exp_pix(input logic [1:0] m,
                                           input int x, input int y,
                                           input int k,
                                           input logic [23:0] s);
      logic [23:0] bars [8];
      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00;
      bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000;
      bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      case (m)
         2'd0: exp_pix = 24'(k);
         2'd1: exp_pix = bars[x / 2];
         2'd2: exp_pix = (((x >> 2) ^ (y >> 2)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
         default: exp_pix = s;
      endcase
   endfunction

   // Consume n pixels starting at the presented one; checks each pixel
   task automatic grab(input int n, input bit bp, input logic [1:0] lm,
                       input logic [23:0] ls);
      int   k = 0;
      int   cyc = 0;
      int   ph = 0;
      bit   held = 1'b0;
      logic [31:0] hv = '0;
      logic rdy;
      logic [3:0] pat = 4'b1001;
      while (k < n && cyc < 1000) begin
         if (held)
            chk("stall_hold", {5'd0, pix_data, pix_sof, pix_eol, pix_eof}, hv);
         chk("valid_in_frame", 32'(pix_valid), 32'd1);
         rdy = bp ? pat[3 - (ph % 4)] : 1'b1;
         ph++;
         pix_ready = rdy;
         if (pix_valid && rdy) begin
            chk("data", 32'(pix_data), 32'(exp_pix(lm, k % 16, k / 16, k, ls)));
            chk("sof", 32'(pix_sof), 32'(k == 0));
            chk("eol", 32'(pix_eol), 32'(k % 16 == 15));
            chk("eof", 32'(pix_eof), 32'(k == 63));
            if (k == 20 && g_apply) begin
               mode      = g_mode;
               solid_rgb = g_solid;
               enable    = g_en;
            end
            k++;
            held = 1'b0;
         end else begin
            held = 1'b1;
            hv   = {5'd0, pix_data, pix_sof, pix_eol, pix_eof};
         end
         @(negedge clk);
         cyc++;
      end
      if (k < n) chk("grab_timeout", 32'(k), 32'(n));
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      mode      = 2'd0;
      solid_rgb = 24'd0;
      pix_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(pix_valid), 32'd0);
      chk("rst_data", 32'(pix_data), 32'd0);
      chk("rst_sof", 32'(pix_sof), 32'd0);
      chk("rst_eol", 32'(pix_eol), 32'd0);
      chk("rst_eof", 32'(pix_eof), 32'd0);
      chk("rst_fcnt", 32'(frame_cnt), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_valid", 32'(pix_valid), 32'd0);
      end

      // Frame 1: ramp; mode change mid-frame only affects frame 2
      enable = 1'b1;
      mode   = 2'd0;
      @(negedge clk);
      chk("start_latency", 32'(pix_valid), 32'd1);
      mode = 2'd1;
      grab(64, 1'b0, 2'd0, 24'd0);
      chk("f1_no_bubble", 32'(pix_valid), 32'd1);
      chk("f1_next_sof", 32'(pix_sof), 32'd1);
      chk("f1_fcnt", 32'(frame_cnt), 32'd1);

      // Frame 2: colour bars
      mode = 2'd2;
      grab(64, 1'b0, 2'd1, 24'd0);
      chk("f2_fcnt", 32'(frame_cnt), 32'd2);

      // Frame 3: checkerboard under backpressure; solid requested mid-frame
      g_apply = 1'b1;
      g_mode  = 2'd3;
      g_solid = 24'h123456;
      g_en    = 1'b1;
      grab(64, 1'b1, 2'd2, 24'd0);
      chk("f3_fcnt", 32'(frame_cnt), 32'd3);
      chk("f4_first", 32'(pix_data), 32'h123456);

      // Frame 4: solid; enable drops mid-frame, frame still completes
      g_mode  = 2'd0;
      g_solid = 24'hABCDEF;
      g_en    = 1'b0;
      grab(64, 1'b1, 2'd3, 24'h123456);
      chk("f4_end_valid", 32'(pix_valid), 32'd0);
      chk("f4_end_eof", 32'(pix_eof), 32'd0);
      chk("f4_fcnt", 32'(frame_cnt), 32'd4);
      repeat (3) @(negedge clk);
      chk("post_idle_valid", 32'(pix_valid), 32'd0);

      // Reset in the middle of a ramp frame
      g_apply = 1'b0;
      mode    = 2'd0;
      enable  = 1'b1;
      @(negedge clk);
      grab(20, 1'b0, 2'd0, 24'd0);
      chk("mid_pix20", 32'(pix_data), 32'd20);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(pix_valid), 32'd0);
      chk("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_valid", 32'(pix_valid), 32'd1);
      chk("restart_data", 32'(pix_data), 32'd0);
      chk("restart_sof", 32'(pix_sof), 32'd1);
      enable = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
